// File: rtl/ro_meas_pkg.sv
// Shared types and default parameters for the ring-oscillator frequency counter.
package ro_meas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } ro_state_t;

    localparam int unsigned RO_COUNT_W       = 16;
    localparam int unsigned RO_WINDOW_CYCLES = 1024;
    localparam int unsigned RO_SETTLE_CYCLES = 8;
    localparam int unsigned RO_SYNC_STAGES   = 2;

    // Width of a counter that must hold the value n itself; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ro_freq_counter_if.sv
// Control/result bus between the frequency counter and its post-processing consumer.
interface ro_freq_counter_if
    import ro_meas_pkg::*;
#(
    parameter int unsigned COUNT_W = RO_COUNT_W
);
    logic               start;
    logic               abort;
    logic               busy;
    logic [COUNT_W-1:0] count;
    logic               count_valid;
    logic               overflow;

    modport master (
        output start, abort,
        input  busy, count, count_valid, overflow
    );

    modport slave (
        input  start, abort,
        output busy, count, count_valid, overflow
    );
endinterface

// File: rtl/ro_sync.sv
// Plain flop-chain synchroniser for the asynchronous ring output.
module ro_sync
    import ro_meas_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = RO_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: enables the ring, lets it settle, counts synchronised
// rising edges over a fixed window and reports the (saturating) result with a valid pulse.
module ro_freq_counter
    import ro_meas_pkg::*;
#(
    parameter int unsigned COUNT_W       = RO_COUNT_W,
    parameter int unsigned WINDOW_CYCLES = RO_WINDOW_CYCLES,
    parameter int unsigned SETTLE_CYCLES = RO_SETTLE_CYCLES,
    parameter int unsigned SYNC_STAGES   = RO_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               osc_in,
    output logic               ro_enable,
    ro_freq_counter_if.slave   bus
);
    localparam int unsigned WinW = cnt_width(WINDOW_CYCLES);
    localparam int unsigned SetW = cnt_width(SETTLE_CYCLES);
    localparam logic [WinW-1:0]    WinLast = WinW'(WINDOW_CYCLES);
    localparam logic [SetW-1:0]    SetLast = SetW'(SETTLE_CYCLES);
    localparam logic [COUNT_W-1:0] AccMax  = '1;

    ro_state_t          state_q, state_d;
    logic [SetW-1:0]    set_cnt_q, set_cnt_d;
    logic [WinW-1:0]    win_cnt_q, win_cnt_d;
    logic [COUNT_W-1:0] acc_q, acc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               osc_prev_q, osc_prev_d;
    logic               osc_sync;
    logic               rise;

    ro_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (osc_in),
        .q   (osc_sync)
    );

    // Edge history runs in every state so an edge already in flight at MEASURE entry counts.
    assign rise = osc_sync & ~osc_prev_q;

    always_comb begin
        state_d    = state_q;
        set_cnt_d  = set_cnt_q;
        win_cnt_d  = win_cnt_q;
        acc_d      = acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        osc_prev_d = osc_sync;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    acc_d      = '0;
                    overflow_d = 1'b0;
                    set_cnt_d  = '0;
                    win_cnt_d  = '0;
                    state_d    = (SETTLE_CYCLES == 0) ? MEASURE : SETTLE;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    set_cnt_d = set_cnt_q + SetW'(1);
                    if (set_cnt_d == SetLast) begin
                        state_d = MEASURE;
                    end
                end
            end
            MEASURE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    win_cnt_d = win_cnt_q + WinW'(1);
                    // Overflow flags an edge that could not be counted.
                    if (rise) begin
                        if (acc_q == AccMax) begin
                            overflow_d = 1'b1;
                        end else begin
                            acc_d = acc_q + COUNT_W'(1);
                        end
                    end
                    if (win_cnt_d == WinLast) begin
                        count_d = acc_d;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            set_cnt_q  <= '0;
            win_cnt_q  <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            osc_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_cnt_q  <= set_cnt_d;
            win_cnt_q  <= win_cnt_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            osc_prev_q <= osc_prev_d;
        end
    end

    assign ro_enable       = (state_q == SETTLE) || (state_q == MEASURE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.count_valid = (state_q == DONE);
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed self-checking bench for ro_freq_counter (default and 4-bit count instances).
module tb_ro_freq_counter;
    logic clk = 1'b0;
    logic rst;
    logic osc_drv;
    logic ring_out = 1'b1;
    logic ring_mode;
    logic osc_in;
    logic ro_en;
    logic ro_en4;

    int checks   = 0;
    int failures = 0;

    int   gen_period = 0;
    logic osc_level  = 1'b1;
    int   ph         = 0;

    ro_freq_counter_if #(.COUNT_W(16)) bus  ();
    ro_freq_counter_if #(.COUNT_W(4))  bus4 ();

    assign osc_in = ring_mode ? ring_out : osc_drv;

    ro_freq_counter #(
        .COUNT_W       (16),
        .WINDOW_CYCLES (1024),
        .SETTLE_CYCLES (8),
        .SYNC_STAGES   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .osc_in    (osc_in),
        .ro_enable (ro_en),
        .bus       (bus)
    );

    ro_freq_counter #(
        .COUNT_W       (4),
        .WINDOW_CYCLES (1024),
        .SETTLE_CYCLES (8),
        .SYNC_STAGES   (2)
    ) dut4 (
        .clk       (clk),
        .rst       (rst),
        .osc_in    (osc_in),
        .ro_enable (ro_en4),
        .bus       (bus4)
    );

    always #5 clk = ~clk;

    // Square-wave source advanced on the falling edge, half high / half low.
    always @(negedge clk) begin
        if (gen_period != 0) begin
            ph      = (ph + 1 >= gen_period) ? 0 : ph + 1;
            osc_drv = (ph < gen_period / 2);
        end else begin
            osc_drv = osc_level;
        end
    end

    // 9-stage ring model: 27 ns half period (9 stages x 3 ns), idles high while disabled.
    always begin
        if (ro_en !== 1'b1) begin
            ring_out = 1'b1;
            wait (ro_en === 1'b1);
        end else begin
            #27;
            ring_out = (ro_en === 1'b1) ? ~ring_out : 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit four, input logic v);
        if (four) bus4.start = v;
        else      bus.start  = v;
    endtask

    task automatic set_abort(input bit four, input logic v);
        if (four) bus4.abort = v;
        else      bus.abort  = v;
    endtask

    // Start a run and watch it; lat = falling edges from start to count_valid, 0 if it never fires.
    task automatic run_meas(input bit four, input int inj_start_at, input int abort_at,
                            input int budget, output int lat, output int en_cyc,
                            output logic ab_busy, output logic ab_en);
        logic cv, en, bz;
        lat     = 0;
        en_cyc  = 0;
        ab_busy = 1'bx;
        ab_en   = 1'bx;
        @(negedge clk);
        set_start(four, 1'b1);
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) set_start(four, 1'b0);
            if (k == inj_start_at) set_start(four, 1'b1);
            if (k == inj_start_at + 1) set_start(four, 1'b0);
            if (k == abort_at) set_abort(four, 1'b1);
            cv = four ? bus4.count_valid : bus.count_valid;
            en = four ? ro_en4 : ro_en;
            bz = four ? bus4.busy : bus.busy;
            if (k == abort_at + 1) begin
                set_abort(four, 1'b0);
                ab_busy = bz;
                ab_en   = en;
            end
            if (en === 1'b1) en_cyc++;
            if (cv === 1'b1) begin
                lat = k;
                break;
            end
        end
        set_start(four, 1'b0);
        set_abort(four, 1'b0);
    endtask

    initial begin
        int   lat, en_cyc, c1, c2;
        logic ab_busy, ab_en;

        rst        = 1'b1;
        ring_mode  = 1'b0;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus4.start = 1'b0;
        bus4.abort = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_busy",  bus.busy, 0);
        chk("rst_en",    ro_en, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_valid", bus.count_valid, 0);
        chk("rst_ovf",   bus.overflow, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Square wave, period 10 clk: 1024-cycle window holds 102 or 103 rising edges.
        gen_period = 10;
        run_meas(1'b0, 0, 0, 3000, lat, en_cyc, ab_busy, ab_en);
        chk("t1_latency", lat, 1033);
        chk("t1_en_cycles", en_cyc, 1032);
        chk("t1_count_range", (bus.count >= 102 && bus.count <= 103) ? 1 : 0, 1);
        chk("t1_ovf", bus.overflow, 0);

        // Ring output stuck high: no edges.
        gen_period = 0;
        osc_level  = 1'b1;
        repeat (4) @(negedge clk);
        run_meas(1'b0, 0, 0, 3000, lat, en_cyc, ab_busy, ab_en);
        chk("t2_latency", lat, 1033);
        chk("t2_en_cycles", en_cyc, 1032);
        chk("t2_count", bus.count, 0);
        chk("t2_ovf", bus.overflow, 0);

        // Start pulsed mid-MEASURE is ignored.
        run_meas(1'b0, 200, 0, 3000, lat, en_cyc, ab_busy, ab_en);
        chk("t4_restart_latency", lat, 1033);
        chk("t4_restart_count", bus.count, 0);

        // Abort in MEASURE cycle 500 (falling edge 8+500): no result, prior count held.
        gen_period = 10;
        run_meas(1'b0, 0, 508, 1200, lat, en_cyc, ab_busy, ab_en);
        chk("t4_abort_no_valid", lat, 0);
        chk("t4_abort_busy", ab_busy, 0);
        chk("t4_abort_en", ab_en, 0);
        chk("t4_abort_count", bus.count, 0);
        chk("t4_abort_ovf", bus.overflow, 0);

        // abort + start together in IDLE: abort wins.
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("idle_abort_wins", bus.busy, 0);

        // 4-bit counter with period-4 input: 256 edges saturate at 15.
        gen_period = 4;
        run_meas(1'b1, 0, 0, 3000, lat, en_cyc, ab_busy, ab_en);
        chk("t3_latency", lat, 1033);
        chk("t3_count", bus4.count, 15);
        chk("t3_ovf", bus4.overflow, 1);
        @(negedge clk);
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        chk("t3_ovf_cleared", bus4.overflow, 0);
        chk("t3_busy", bus4.busy, 1);
        bus4.abort = 1'b1;
        @(negedge clk);
        bus4.abort = 1'b0;
        chk("t3_abort_settle", bus4.busy, 0);
        chk("t3_count_held", bus4.count, 15);

        // Reset in SETTLE, then in MEASURE.
        gen_period = 10;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5a_busy", bus.busy, 0);
        chk("t5a_en", ro_en, 0);
        chk("t5a_valid", bus.count_valid, 0);
        chk("t5a_count4", bus4.count, 0);
        chk("t5a_ovf4", bus4.overflow, 0);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5b_busy", bus.busy, 0);
        chk("t5b_en", ro_en, 0);
        chk("t5b_valid", bus.count_valid, 0);
        chk("t5b_count", bus.count, 0);
        run_meas(1'b0, 0, 0, 3000, lat, en_cyc, ab_busy, ab_en);
        chk("t5_after_latency", lat, 1033);
        chk("t5_after_count", (bus.count >= 102 && bus.count <= 103) ? 1 : 0, 1);

        // Closed loop: 54 ns ring period over a 10240 ns window, about 189-190 edges.
        ring_mode = 1'b1;
        run_meas(1'b0, 0, 0, 3000, lat, en_cyc, ab_busy, ab_en);
        chk("t6_run1_latency", lat, 1033);
        c1 = int'(bus.count);
        run_meas(1'b0, 0, 0, 3000, lat, en_cyc, ab_busy, ab_en);
        chk("t6_run2_latency", lat, 1033);
        c2 = int'(bus.count);
        chk("t6_run1_range", (c1 >= 185 && c1 <= 195) ? 1 : 0, 1);
        chk("t6_repeat", ((c1 - c2) <= 1 && (c2 - c1) <= 1) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
